alu_ctrl_md: RTL and testbench

//  Registered successor to the ID-stage ALU control decoder for the pipelined MIPS core. Decodes R-type func into

---
 rtl/alu_ctrl_md.sv | 181 ++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// ALU control decoder registered into EX, plus an iterative multiply/divide unit owning HI/LO.
// Decode latency 1 cycle; mul/div busy W+1 cycles; HI/LO users stall while the unit is busy.
module alu_ctrl_md #(
  parameter int W      = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [5:0]   func,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         flush,
  output logic         stall,
  output logic         ex_valid,
  output logic [4:0]   aluc,
  output logic         shfsrc,
  output logic         jar,
  output logic         jr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;

  logic [4:0]     dec_aluc;
  logic           dec_shf, dec_jar, dec_jr;
  logic           is_md, is_div, is_signed, hilo_use, is_mthi, is_mtlo;
  logic           accept, start;
  logic [W-1:0]   rs_abs, rt_abs, b;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           op_div, neg_q, neg_r, divz;
  logic [W:0]     mul_sum, div_sub;
  logic [2*W-1:0] mul_step, div_step, prod;
  logic [W-1:0]   quo, rem;

  always_comb begin
    dec_aluc  = 5'b11111;
    dec_shf   = 1'b0;
    dec_jar   = 1'b0;
    dec_jr    = 1'b0;
    is_md     = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    hilo_use  = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (func)
      6'b100001: dec_aluc = 5'b00000;
      6'b100011: dec_aluc = 5'b00001;
      6'b101010: dec_aluc = 5'b00010;
      6'b100100: dec_aluc = 5'b00011;
      6'b100111: dec_aluc = 5'b00100;
      6'b100101: dec_aluc = 5'b00101;
      6'b100110: dec_aluc = 5'b00110;
      6'b000000: begin dec_aluc = 5'b00111; dec_shf = 1'b1; end
      6'b000100: dec_aluc = 5'b00111;
      6'b101011: dec_aluc = 5'b01000;
      6'b000010: begin dec_aluc = 5'b01010; dec_shf = 1'b1; end
      6'b000110: dec_aluc = 5'b01010;
      6'b000011: begin dec_aluc = 5'b10101; dec_shf = 1'b1; end
      6'b000111: dec_aluc = 5'b10101;
      6'b001000: begin dec_aluc = 5'b10111; dec_jr = 1'b1; end
      6'b001001: begin dec_aluc = 5'b10111; dec_jr = 1'b1; dec_jar = 1'b1; end
      6'b010000: begin dec_aluc = 5'b01011; hilo_use = 1'b1; end
      6'b010010: begin dec_aluc = 5'b01100; hilo_use = 1'b1; end
      6'b010001: begin dec_aluc = 5'b01101; hilo_use = 1'b1; is_mthi = 1'b1; end
      6'b010011: begin dec_aluc = 5'b01101; hilo_use = 1'b1; is_mtlo = 1'b1; end
      6'b011000: begin dec_aluc = 5'b01101; hilo_use = 1'b1; is_md = 1'b1; is_signed = 1'b1; end
      6'b011001: begin dec_aluc = 5'b01101; hilo_use = 1'b1; is_md = 1'b1; end
      6'b011010: if (DIV_EN) begin
        dec_aluc = 5'b01101; hilo_use = 1'b1; is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1;
      end
      6'b011011: if (DIV_EN) begin
        dec_aluc = 5'b01101; hilo_use = 1'b1; is_md = 1'b1; is_div = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE);
  assign stall  = valid_in & busy & hilo_use;
  assign accept = valid_in & ~stall & ~flush;
  assign start  = accept & is_md;

  assign rs_abs = (is_signed & rs_val[W-1]) ? (~rs_val + 1'b1) : rs_val;
  assign rt_abs = (is_signed & rt_val[W-1]) ? (~rt_val + 1'b1) : rt_val;

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : {(W+1){1'b0}});
  assign mul_step = {mul_sum, acc[W-1:1]};
  // Restoring divide: remainder in the high half, quotient bits enter at the bottom.
  assign div_sub  = acc[2*W-1:W-1] - {1'b0, b};
  assign div_step = div_sub[W] ? {acc[2*W-2:0], 1'b0} : {div_sub[W-1:0], acc[W-2:0], 1'b1};

  assign prod = neg_q ? (~acc + 1'b1) : acc;
  assign quo  = divz ? {W{1'b1}} : (neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0]);
  assign rem  = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (flush) state_nx = IDLE; else if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      aluc     <= 5'b11111;
      shfsrc   <= 1'b0;
      jar      <= 1'b0;
      jr       <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      aluc     <= dec_aluc;
      shfsrc   <= dec_shf;
      jar      <= dec_jar;
      jr       <= dec_jr;
    end else begin
      ex_valid <= 1'b0;
      aluc     <= 5'b11111;
      shfsrc   <= 1'b0;
      jar      <= 1'b0;
      jr       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      b      <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX) & ~flush;
      if (start) begin
        op_div <= is_div;
        neg_q  <= is_signed & (rs_val[W-1] ^ rt_val[W-1]);
        neg_r  <= is_signed & rs_val[W-1];
        divz   <= (rt_val == '0);
        b      <= is_div ? rt_abs : rs_abs;
        acc    <= {{W{1'b0}}, (is_div ? rs_abs : rt_abs)};
        cnt    <= CW'(W - 1);
      end else if (state == RUN) begin
        acc <= op_div ? div_step : mul_step;
        cnt <= cnt - 1'b1;
      end
      if ((state == FIX) && !flush) begin
        if (op_div) begin
          hi <= rem;
          lo <= quo;
        end else begin
          {hi, lo} <= prod;
        end
      end else begin
        if (accept && is_mthi) hi <= rs_val;
        if (accept && is_mtlo) lo <= rs_val;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: decode table, directed mul/div corners, random mul/div vs model.
module tb_alu_ctrl_md;
  localparam int W = 32;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MTHI = 6'b010001, F_MTLO = 6'b010011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, valid_in, flush;
  logic [5:0] func;
  logic [W-1:0] rs_val, rt_val;
  logic stall, ex_valid, shfsrc, jar, jr, busy, done;
  logic [4:0] aluc;
  logic [W-1:0] hi, lo;
  logic n_stall, n_ex_valid, n_shfsrc, n_jar, n_jr, n_busy, n_done;
  logic [4:0] n_aluc;
  logic [W-1:0] n_hi, n_lo;

  alu_ctrl_md #(.W(W), .DIV_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .func(func), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .aluc(aluc), .shfsrc(shfsrc), .jar(jar), .jr(jr),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  alu_ctrl_md #(.W(W), .DIV_EN(1'b0)) u_nodiv (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .func(func), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .stall(n_stall), .ex_valid(n_ex_valid), .aluc(n_aluc), .shfsrc(n_shfsrc), .jar(n_jar),
    .jr(n_jr), .busy(n_busy), .done(n_done), .hi(n_hi), .lo(n_lo));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference results {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return 64'(ua * ub);
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    valid_in = 1'b1; func = f; rs_val = a; rt_val = b;
    tick;
    valid_in = 1'b0;
    chk({tag, "_aluc"}, {ex_valid, aluc}, {1'b1, 5'b01101});
    if (f == F_DIV || f == F_DIVU) chk({tag, "_nodiv"}, {n_busy, n_aluc}, {1'b0, 5'b11111});
    n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, md_model(f, a, b));
    tick;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    valid_in = 1'b1; func = F_MTHI; rs_val = h;
    tick;
    func = F_MTLO; rs_val = l;
    tick;
    valid_in = 1'b0;
  endtask

  typedef struct {
    logic [5:0] f;
    logic [4:0] aluc;
    logic       shf, jar, jr;
  } dec_vec_t;
  dec_vec_t vt[21];

  initial begin
    int n;
    bit bad;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [63:0] exp;

    vt[0]  = '{6'b100001, 5'b00000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{6'b100011, 5'b00001, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{6'b101010, 5'b00010, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{6'b100100, 5'b00011, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{6'b100111, 5'b00100, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{6'b100101, 5'b00101, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{6'b100110, 5'b00110, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{6'b000000, 5'b00111, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{6'b000100, 5'b00111, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{6'b101011, 5'b01000, 1'b0, 1'b0, 1'b0};
    vt[10] = '{6'b000010, 5'b01010, 1'b1, 1'b0, 1'b0};
    vt[11] = '{6'b000110, 5'b01010, 1'b0, 1'b0, 1'b0};
    vt[12] = '{6'b000011, 5'b10101, 1'b1, 1'b0, 1'b0};
    vt[13] = '{6'b000111, 5'b10101, 1'b0, 1'b0, 1'b0};
    vt[14] = '{6'b001000, 5'b10111, 1'b0, 1'b0, 1'b1};
    vt[15] = '{6'b001001, 5'b10111, 1'b0, 1'b1, 1'b1};
    vt[16] = '{6'b010000, 5'b01011, 1'b0, 1'b0, 1'b0};
    vt[17] = '{6'b010010, 5'b01100, 1'b0, 1'b0, 1'b0};
    vt[18] = '{6'b100000, 5'b11111, 1'b0, 1'b0, 1'b0};
    vt[19] = '{6'b100010, 5'b11111, 1'b0, 1'b0, 1'b0};
    vt[20] = '{6'b001100, 5'b11111, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; func = '0; rs_val = '0; rt_val = '0;
    tick;
    tick;
    chk("reset_state", {ex_valid, aluc, shfsrc, jar, jr, busy, done, stall},
        {1'b0, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    tick;

    // Decode table
    for (int i = 0; i < 21; i++) begin
      valid_in = 1'b1; func = vt[i].f;
      tick;
      chk($sformatf("decode_%b", vt[i].f), {ex_valid, aluc, shfsrc, jar, jr},
          {1'b1, vt[i].aluc, vt[i].shf, vt[i].jar, vt[i].jr});
    end
    valid_in = 1'b1; func = 6'b100001; flush = 1'b1;
    tick;
    chk("flush_bubble", {ex_valid, aluc}, {1'b0, 5'b11111});
    flush = 1'b0; valid_in = 1'b0;
    tick;
    chk("idle_bubble", {ex_valid, aluc, shfsrc, jar, jr}, {1'b0, 5'b11111, 3'b000});

    // mthi/mtlo, then directed mul/div corners
    write_hilo(32'hCAFE_0001, 32'hBEEF_0002);
    chk("mthi_mtlo", {hi, lo}, {32'hCAFE_0001, 32'hBEEF_0002});
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'h2, "multu_max");
    chk("multu_max_const", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
    run_md(F_DIV, 32'hFFFF_FFF9, 32'h2, "div_neg7");
    chk("div_neg7_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    chk("div_min_const", {hi, lo}, {32'h0, 32'h8000_0000});
    run_md(F_DIVU, 32'h5, 32'h0, "divu_zero");
    chk("divu_zero_const", {hi, lo}, {32'h5, 32'hFFFF_FFFF});
    run_md(F_DIV, 32'hFFFF_FFF0, 32'h0, "div_zero_neg");
    run_md(F_MULT, 32'hFFFF_FFFD, 32'h7, "mult_neg");

    // mflo held while busy: stall and bubble until done
    valid_in = 1'b1; func = F_MULT; rs_val = 32'h1234_5678; rt_val = 32'hFEDC_BA98;
    exp = md_model(F_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    tick;
    func = F_MFLO;
    bad = 1'b0; n = 0;
    while (busy && n < 100) begin
      if (!stall) bad = 1'b1;
      tick;
      n++;
      if (ex_valid || aluc != 5'b11111) bad = 1'b1;
    end
    chk("mflo_stall_bubbles", {63'h0, bad}, 64'h0);
    chk("mflo_wait_cycles", 64'(n), 64'(W + 1));
    chk("mflo_release", {stall, done}, {1'b0, 1'b1});
    chk("mflo_lo_new", {32'h0, lo}, {32'h0, exp[31:0]});
    tick;
    chk("mflo_decoded", {ex_valid, aluc}, {1'b1, 5'b01100});
    valid_in = 1'b0;
    tick;

    // Non-HI/LO op while busy, then flush 10 cycles into mult
    write_hilo(32'h1111_1111, 32'h2222_2222);
    valid_in = 1'b1; func = F_MULT; rs_val = 32'h9; rt_val = 32'h9;
    tick;
    func = 6'b100001;
    #1;
    chk("addu_no_stall", {63'h0, stall}, 64'h0);
    tick;
    chk("addu_while_busy", {ex_valid, aluc, busy}, {1'b1, 5'b00000, 1'b1});
    valid_in = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy", {busy, done}, {1'b0, 1'b0});
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done || busy) bad = 1'b1;
    end
    chk("flush_no_done", {63'h0, bad}, 64'h0);
    chk("flush_hilo_kept", {hi, lo}, {32'h1111_1111, 32'h2222_2222});

    // Flush in the last busy cycle beats the HI/LO write
    valid_in = 1'b1; func = F_MULTU; rs_val = 32'h3; rt_val = 32'h5;
    tick;
    valid_in = 1'b0;
    for (int i = 0; i < W; i++) tick;
    chk("fix_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fix_flush", {busy, done}, {1'b0, 1'b0});
    tick;
    chk("fix_flush_hilo", {done, hi, lo}, {1'b0, 32'h1111_1111, 32'h2222_2222});

    // Reset mid-divide
    valid_in = 1'b1; func = F_DIVU; rs_val = 32'h100; rt_val = 32'h3;
    tick;
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst_n = 1'b0;
    #1;
    chk("midreset_state", {ex_valid, aluc, busy, done}, {1'b0, 5'b11111, 1'b0, 1'b0});
    chk("midreset_hilo", {hi, lo}, 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("after_reset_idle", {63'h0, busy}, 64'h0);

    // Random mul/div against the model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_md(f, a, b, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
